// File: rtl/tilelink_ul_formal_slave_pkg.sv
// rtl/tilelink_ul_formal_slave_pkg.sv - TileLink opcodes, request entry type and beat helpers
package tl_formal_pkg;

  localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_A_ARITH       = 3'd2;
  localparam logic [2:0] TL_A_LOGIC       = 3'd3;
  localparam logic [2:0] TL_A_GET         = 3'd4;
  localparam logic [2:0] TL_A_INTENT      = 3'd5;

  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] TL_D_HINT_ACK        = 3'd2;

  localparam int TL_MAX_SIZE_W   = 8;
  localparam int TL_MAX_SOURCE_W = 8;
  localparam int TL_CNT_W        = 16;

  // Fields are sized for the widest supported SIZE_W/SOURCE_W; the top zero-extends.
  typedef struct packed {
    logic [2:0]                 opcode;
    logic [TL_MAX_SIZE_W-1:0]   size;
    logic [TL_MAX_SOURCE_W-1:0] source;
  } tl_req_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BEAT = 1'b1
  } d_state_e;

  function automatic logic [TL_CNT_W-1:0] beats(input logic [TL_MAX_SIZE_W-1:0] size,
                                                input logic [TL_MAX_SIZE_W-1:0] lg_bytes);
    if (size <= lg_bytes) return TL_CNT_W'(1);
    return TL_CNT_W'(1) << (size - lg_bytes);
  endfunction

  function automatic logic a_has_data(input logic [2:0] op);
    return (op <= TL_A_LOGIC);
  endfunction

  function automatic logic d_has_data(input logic [2:0] op);
    return (op == TL_A_GET) || (op == TL_A_ARITH) || (op == TL_A_LOGIC);
  endfunction

  function automatic logic [2:0] d_opcode_of(input logic [2:0] op);
    if (d_has_data(op)) return TL_D_ACCESS_ACK_DATA;
    if (op == TL_A_INTENT) return TL_D_HINT_ACK;
    return TL_D_ACCESS_ACK;
  endfunction

endpackage

// File: rtl/tilelink_ul_formal_slave_if.sv
// rtl/tilelink_ul_formal_slave_if.sv - TileLink A/D channels plus free nondeterministic inputs
interface tilelink_ul_formal_slave_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SIZE_W   = 4,
  parameter int SOURCE_W = 1
);
  localparam int BYTES = DATA_W / 8;

  logic                a_ready;
  logic                a_valid;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [SIZE_W-1:0]   a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [BYTES-1:0]    a_mask;
  logic [DATA_W-1:0]   a_data;

  logic                d_ready;
  logic                d_valid;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [SIZE_W-1:0]   d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_sink;
  logic [DATA_W-1:0]   d_data;
  logic                d_error;

  logic                nd_stall_a;
  logic                nd_stall_d;
  logic [DATA_W-1:0]   nd_data;
  logic                nd_error;

  modport slave (
    output a_ready,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  d_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  nd_stall_a, nd_stall_d, nd_data, nd_error
  );

  modport master (
    input  a_ready,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output d_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output nd_stall_a, nd_stall_d, nd_data, nd_error
  );

endinterface

// File: rtl/tilelink_ul_formal_slave_fifo.sv
// rtl/tilelink_ul_formal_slave_fifo.sv - request queue with head and second-entry peek
module tl_req_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] rd_next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  // rd_next_o is only meaningful while count_o > 1.
  assign rd_next_o = mem_q[next_ptr(rd_ptr_q)];

  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/tilelink_ul_formal_slave.sv
// rtl/tilelink_ul_formal_slave.sv - TileLink-UL/UH formal slave: queued in-order replies with nondeterministic data
module tilelink_ul_formal_slave
  import tl_formal_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int SIZE_W     = 4,
  parameter int SOURCE_W   = 1,
  parameter int QDEPTH     = 2,
  parameter bit ERR_INJECT = 1'b0,
  parameter bit FAST_MEM   = 1'b0
) (
  input logic                      clock,
  input logic                      reset,
  tilelink_ul_formal_slave_if.slave tl
);

  localparam int                      BYTES    = DATA_W / 8;
  localparam logic [TL_MAX_SIZE_W-1:0] LG_BYTES = TL_MAX_SIZE_W'($clog2(BYTES));
  localparam int                      CW       = $clog2(QDEPTH + 1);

  logic                full, empty;
  logic [CW-1:0]       count;
  tl_req_t             head, next;

  // A channel: beat counting and header capture
  tl_req_t             a_in, a_cur, a_hdr_q, a_hdr_d;
  logic [TL_CNT_W-1:0] a_cnt_q, a_cnt_d, a_beats;
  logic                a_ready, a_fire, a_last, push;

  assign a_ready    = !full && !reset && !(tl.nd_stall_a && !FAST_MEM);
  assign tl.a_ready = a_ready;
  assign a_fire     = tl.a_valid && a_ready;

  always_comb begin
    a_in.opcode = tl.a_opcode;
    a_in.size   = TL_MAX_SIZE_W'(tl.a_size);
    a_in.source = TL_MAX_SOURCE_W'(tl.a_source);
    a_cur       = (a_cnt_q == '0) ? a_in : a_hdr_q;
    a_beats     = a_has_data(a_cur.opcode) ? beats(a_cur.size, LG_BYTES) : TL_CNT_W'(1);
    a_last      = (a_cnt_q == a_beats - TL_CNT_W'(1));
    push        = a_fire && a_last;
    a_cnt_d     = a_cnt_q;
    a_hdr_d     = a_hdr_q;
    if (a_fire) begin
      a_cnt_d = a_last ? '0 : a_cnt_q + TL_CNT_W'(1);
      if (a_cnt_q == '0) a_hdr_d = a_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt_q <= '0;
      a_hdr_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      a_hdr_q <= a_hdr_d;
    end
  end

  // D channel FSM
  d_state_e            state_q, state_d;
  logic [TL_CNT_W-1:0] d_cnt_q, d_cnt_d, d_beats;
  logic                d_fire, d_last, stall_d, pop, load;
  tl_req_t             load_req;

  logic [2:0]          d_opcode_q;
  logic [SIZE_W-1:0]   d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic [DATA_W-1:0]   d_data_q;
  logic                d_error_q;

  tl_req_fifo #(
    .WIDTH ($bits(tl_req_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (push),
    .wr_data_i (a_cur),
    .pop_i     (pop),
    .rd_data_o (head),
    .rd_next_o (next),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  always_comb begin
    state_d  = state_q;
    d_cnt_d  = d_cnt_q;
    pop      = 1'b0;
    load     = 1'b0;
    load_req = head;
    stall_d  = tl.nd_stall_d && !FAST_MEM;
    d_fire   = (state_q == D_BEAT) && tl.d_ready;
    d_beats  = d_has_data(head.opcode) ? beats(head.size, LG_BYTES) : TL_CNT_W'(1);
    d_last   = (d_cnt_q == d_beats - TL_CNT_W'(1));
    case (state_q)
      D_IDLE: begin
        if (!empty && !stall_d) begin
          state_d = D_BEAT;
          load    = 1'b1;
        end
      end
      D_BEAT: begin
        if (d_fire) begin
          if (d_last) begin
            pop     = 1'b1;
            d_cnt_d = '0;
            // Entries pushed this cycle are not yet visible: no bypass.
            if ((count > CW'(1)) && !stall_d) begin
              load     = 1'b1;
              load_req = next;
            end else begin
              state_d = D_IDLE;
            end
          end else begin
            d_cnt_d = d_cnt_q + TL_CNT_W'(1);
            if (!stall_d) load = 1'b1;
            else          state_d = D_IDLE;
          end
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= D_IDLE;
      d_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  // Output registers change only on a beat load, so they stay stable while stalled.
  always_ff @(posedge clock) begin
    if (reset || (!load && state_d == D_IDLE)) begin
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else if (load) begin
      d_opcode_q <= d_opcode_of(load_req.opcode);
      d_size_q   <= SIZE_W'(load_req.size);
      d_source_q <= SOURCE_W'(load_req.source);
      d_data_q   <= d_has_data(load_req.opcode) ? tl.nd_data : '0;
      if (load_req.opcode[2:1] == 2'b11)
        d_error_q <= 1'b1;
      else
        d_error_q <= d_has_data(load_req.opcode) && ERR_INJECT && tl.nd_error;
    end
  end

  assign tl.d_valid  = (state_q == D_BEAT);
  assign tl.d_opcode = d_opcode_q;
  assign tl.d_param  = 2'b00;
  assign tl.d_size   = d_size_q;
  assign tl.d_source = d_source_q;
  assign tl.d_sink   = 1'b0;
  assign tl.d_data   = d_data_q;
  assign tl.d_error  = d_error_q;

  logic unused_ok;
  assign unused_ok = ^{tl.a_param, tl.a_address, tl.a_mask, tl.a_data, head, next, load_req};

endmodule

// File: tb/tb_tilelink_ul_formal_slave.sv
// tb/tb_tilelink_ul_formal_slave.sv - directed bench for tilelink_ul_formal_slave
module tb_tilelink_ul_formal_slave;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  tilelink_ul_formal_slave_if #(.DATA_W(32), .ADDR_W(32), .SIZE_W(4), .SOURCE_W(1)) bus ();

  tilelink_ul_formal_slave #(
    .DATA_W(32), .ADDR_W(32), .SIZE_W(4), .SOURCE_W(1),
    .QDEPTH(2), .ERR_INJECT(1'b1), .FAST_MEM(1'b0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tl    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [3:0] size, input logic src);
    int n = 0;
    bus.a_valid  = 1'b1;
    bus.a_opcode = op;
    bus.a_size   = size;
    bus.a_source = src;
    bus.a_data   = $urandom;
    #1;
    while (!bus.a_ready && n < 20) begin
      tick();
      n++;
    end
    chk("a_accept", {31'd0, bus.a_ready}, 32'd1);
    tick();
    bus.a_valid = 1'b0;
  endtask

  task automatic d_beat(input string tag, input logic [2:0] op, input logic [3:0] size,
                        input logic src, input logic [31:0] data, input logic err,
                        input logic [31:0] next_nd);
    int n = 0;
    while (!bus.d_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"},  {31'd0, bus.d_valid},  32'd1);
    chk({tag, "_opcode"}, {29'd0, bus.d_opcode}, {29'd0, op});
    chk({tag, "_size"},   {28'd0, bus.d_size},   {28'd0, size});
    chk({tag, "_source"}, {31'd0, bus.d_source}, {31'd0, src});
    chk({tag, "_data"},   bus.d_data,            data);
    chk({tag, "_error"},  {31'd0, bus.d_error},  {31'd0, err});
    bus.nd_data = next_nd;
    bus.d_ready = 1'b1;
    tick();
    bus.d_ready = 1'b0;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_opcode = 0; bus.a_param = 0; bus.a_size = 0; bus.a_source = 0;
    bus.a_address = 0; bus.a_mask = 0; bus.a_data = 0; bus.d_ready = 0;
    bus.nd_stall_a = 0; bus.nd_stall_d = 0; bus.nd_data = 0; bus.nd_error = 0;

    repeat (3) tick();
    chk("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("rst_d_data", bus.d_data, 32'd0);
    chk("rst_d_opcode", {29'd0, bus.d_opcode}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, bus.a_ready}, 32'd1);
    bus.nd_stall_a = 1'b1;
    #1;
    chk("stall_a_blocks", {31'd0, bus.a_ready}, 32'd0);
    bus.nd_stall_a = 1'b0;

    // single-beat Get
    bus.nd_data = 32'hDEADBEEF;
    send_a(3'd4, 4'd2, 1'b1);
    chk("get_no_bypass", {31'd0, bus.d_valid}, 32'd0);
    d_beat("get1", 3'd1, 4'd2, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("get1_done", {31'd0, bus.d_valid}, 32'd0);

    // four-beat Get, fresh nd_data each beat
    bus.nd_data = 32'h100;
    send_a(3'd4, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++)
      d_beat("get4", 3'd1, 4'd4, 1'b0, 32'h100 + i, 1'b0, 32'h101 + i);
    chk("get4_done", {31'd0, bus.d_valid}, 32'd0);

    // two-beat PutFull; second beat header fields are ignored
    send_a(3'd0, 4'd3, 1'b0);
    tick();
    chk("put_wait_2nd", {31'd0, bus.d_valid}, 32'd0);
    send_a(3'd4, 4'd0, 1'b1);
    d_beat("put", 3'd0, 4'd3, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("put_done", {31'd0, bus.d_valid}, 32'd0);

    // queue full with D stalled; outputs hold while nd_data moves
    bus.nd_data = 32'hA1A1A1A1;
    send_a(3'd4, 4'd2, 1'b0);
    send_a(3'd4, 4'd2, 1'b1);
    bus.a_valid = 1'b1; bus.a_opcode = 3'd4; bus.a_size = 4'd2; bus.a_source = 1'b0;
    #1;
    chk("full_a_ready", {31'd0, bus.a_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.nd_data = 32'h55550000 + i;
      tick();
      chk("stall_valid", {31'd0, bus.d_valid}, 32'd1);
      chk("stall_data", bus.d_data, 32'hA1A1A1A1);
    end
    bus.a_valid = 1'b0;
    d_beat("q1", 3'd1, 4'd2, 1'b0, 32'hA1A1A1A1, 1'b0, 32'hB2B2B2B2);
    d_beat("q2", 3'd1, 4'd2, 1'b1, 32'hB2B2B2B2, 1'b0, 32'h0);
    chk("q_done", {31'd0, bus.d_valid}, 32'd0);

    // reserved opcode and Intent
    send_a(3'd6, 4'd2, 1'b0);
    d_beat("op6", 3'd0, 4'd2, 1'b0, 32'h0, 1'b1, 32'h0);
    send_a(3'd5, 4'd1, 1'b1);
    d_beat("intent", 3'd2, 4'd1, 1'b1, 32'h0, 1'b0, 32'h0);

    // injected error on a Get
    bus.nd_error = 1'b1;
    bus.nd_data  = 32'h0E770E77;
    send_a(3'd4, 4'd2, 1'b0);
    d_beat("errinj", 3'd1, 4'd2, 1'b0, 32'h0E770E77, 1'b1, 32'h0);
    bus.nd_error = 1'b0;

    // two-beat Arith in, two data beats out
    bus.nd_data = 32'h300;
    send_a(3'd2, 4'd3, 1'b1);
    send_a(3'd2, 4'd3, 1'b1);
    d_beat("arith0", 3'd1, 4'd3, 1'b1, 32'h300, 1'b0, 32'h301);
    d_beat("arith1", 3'd1, 4'd3, 1'b1, 32'h301, 1'b0, 32'h0);
    chk("arith_done", {31'd0, bus.d_valid}, 32'd0);

    // reset in the middle of a four-beat Get
    bus.nd_data = 32'h700;
    send_a(3'd4, 4'd4, 1'b0);
    d_beat("rst_b0", 3'd1, 4'd4, 1'b0, 32'h700, 1'b0, 32'h701);
    chk("mid_burst_valid", {31'd0, bus.d_valid}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    chk("mid_rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    chk("mid_rst_d_data", bus.d_data, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.a_ready}, 32'd1);
    bus.nd_data = 32'hCAFE0001;
    send_a(3'd4, 4'd2, 1'b1);
    d_beat("post_rst", 3'd1, 4'd2, 1'b1, 32'hCAFE0001, 1'b0, 32'h0);
    chk("post_rst_done", {31'd0, bus.d_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
